// File: rtl/nmr_pkg.sv
// Shared types and constants for the N-modular-redundancy voter and its
// per-channel health monitors.
package nmr_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        HEALTHY   = 2'b00,
        FAULTED   = 2'b01,
        PROBATION = 2'b10
    } chan_state_t;

    typedef enum logic [1:0] {
        MODE_NMR     = 2'b00,
        MODE_DUPLEX  = 2'b01,
        MODE_SIMPLEX = 2'b10
    } mode_t;

endpackage

// File: rtl/nmr_chan_monitor.sv
// Per-channel health FSM: counts consecutive disagreements to isolate a lane
// and consecutive agreements to bring a reintegrated lane back into the vote.
module nmr_chan_monitor
    import nmr_pkg::*;
#(
    parameter int FAULT_THRESH = 3,
    parameter int REINT_CNT    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        update_en,
    input  logic        match,
    input  logic        reint_req,
    output chan_state_t state,
    output logic        healthy
);

    chan_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= HEALTHY;
            cnt     <= '0;
            healthy <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            healthy <= (state_nxt == HEALTHY);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (update_en) begin
            case (state)
                HEALTHY: begin
                    if (match) begin
                        cnt_nxt = '0;
                    end else if (cnt_inc >= CNT_W'(FAULT_THRESH)) begin
                        state_nxt = FAULTED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                PROBATION: begin
                    if (!match) begin
                        state_nxt = FAULTED;
                        cnt_nxt   = '0;
                    end else if (cnt_inc >= CNT_W'(REINT_CNT)) begin
                        state_nxt = HEALTHY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = state;
                    cnt_nxt   = cnt;
                end
            endcase
        end
        // Reintegration acts on the post-update state, so it wins over a same-edge isolation.
        if (reint_req && state_nxt == FAULTED) begin
            state_nxt = PROBATION;
            cnt_nxt   = '0;
        end
    end

endmodule

// File: rtl/nmr_voter.sv
// N-modular-redundancy voter: bitwise majority over healthy lanes with
// lowest-index tie-break, degrading NMR -> duplex -> simplex as lanes are isolated.
module nmr_voter
    import nmr_pkg::*;
#(
    parameter int DATA_LEN     = 8,
    parameter int N_CH         = 5,
    parameter int FAULT_THRESH = 3,
    parameter int REINT_CNT    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_CH*DATA_LEN-1:0]     data_in,
    input  logic [N_CH-1:0]              error_ctrl,
    input  logic                         in_valid,
    input  logic [N_CH-1:0]              reint_req,
    output logic [DATA_LEN-1:0]          data_out,
    output logic                         out_valid,
    output logic                         TMR_error,
    output logic [N_CH-1:0]              fault_vec,
    output logic [$clog2(N_CH+1)-1:0]    healthy_cnt,
    output logic [1:0]                   mode
);

    localparam int HC_W = $clog2(N_CH+1);

    // Handshake: data_in is consumed on every edge where in_valid=1 (no backpressure);
    // out_valid pulses exactly one cycle later for each consumed sample.

    logic [DATA_LEN-1:0] w [N_CH];
    logic [N_CH-1:0]     healthy;
    chan_state_t         chan_state [N_CH];
    logic [HC_W-1:0]     h_cnt;
    logic [HC_W-1:0]     ones;
    logic [HC_W-1:0]     agree;
    logic [DATA_LEN-1:0] low_word;
    logic [DATA_LEN-1:0] high_word;
    logic [DATA_LEN-1:0] maj_word;
    logic [DATA_LEN-1:0] voted;
    logic                word_majority;
    logic                vote_error;
    logic                nmr_active;
    logic                update_en;
    logic [N_CH-1:0]     match;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w[i] = data_in[i*DATA_LEN +: DATA_LEN] ^ {DATA_LEN{error_ctrl[i]}};
        end
    end

    always_comb begin
        h_cnt     = '0;
        low_word  = '0;
        high_word = '0;
        for (int i = 0; i < N_CH; i++) begin
            h_cnt = h_cnt + HC_W'(healthy[i]);
            if (healthy[i]) high_word = w[i];
        end
        for (int i = N_CH-1; i >= 0; i--) begin
            if (healthy[i]) low_word = w[i];
        end
    end

    // Per-bit strict majority; an even split falls back to the lowest healthy lane.
    always_comb begin
        maj_word = '0;
        ones     = '0;
        for (int b = 0; b < DATA_LEN; b++) begin
            ones = '0;
            for (int i = 0; i < N_CH; i++) begin
                if (healthy[i] && w[i][b]) ones = ones + HC_W'(1);
            end
            if ({ones, 1'b0} > {1'b0, h_cnt})
                maj_word[b] = 1'b1;
            else if ({ones, 1'b0} == {1'b0, h_cnt})
                maj_word[b] = low_word[b];
            else
                maj_word[b] = 1'b0;
        end
    end

    always_comb begin
        agree = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (healthy[i] && (w[i] == maj_word)) agree = agree + HC_W'(1);
        end
        word_majority = ({agree, 1'b0} > {1'b0, h_cnt});
    end

    assign nmr_active = (h_cnt >= HC_W'(3));

    always_comb begin
        voted      = low_word;
        vote_error = 1'b0;
        if (nmr_active) begin
            voted      = maj_word;
            vote_error = !word_majority;
        end else if (h_cnt == HC_W'(2)) begin
            voted      = low_word;
            vote_error = (low_word != high_word);
        end
    end

    // Health bookkeeping only advances when a trustworthy majority exists.
    assign update_en = in_valid && nmr_active && word_majority;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_mon
            assign match[g] = (w[g] == voted);

            nmr_chan_monitor #(
                .FAULT_THRESH (FAULT_THRESH),
                .REINT_CNT    (REINT_CNT)
            ) u_mon (
                .clk       (clk),
                .reset     (reset),
                .update_en (update_en),
                .match     (match[g]),
                .reint_req (reint_req[g]),
                .state     (chan_state[g]),
                .healthy   (healthy[g])
            );

            assign fault_vec[g] = (chan_state[g] != HEALTHY);
        end
    endgenerate

    assign healthy_cnt = h_cnt;

    always_comb begin
        mode_t m;
        m = MODE_SIMPLEX;
        if (nmr_active)
            m = MODE_NMR;
        else if (h_cnt == HC_W'(2))
            m = MODE_DUPLEX;
        mode = m;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            TMR_error <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out  <= voted;
                TMR_error <= vote_error;
            end
        end
    end

endmodule
